// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : RAW-hazard stall, branch flush and debug halt/step sequencing for
//            a 5-stage pipeline without forwarding.
//            Optional: HAZARD_PERF_EN adds saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int RA_W    = 2,
  parameter int STALL_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [RA_W-1:0]    i_id_rs,
  input  logic               i_id_rs_used,
  input  logic               i_id_rd_used,
  input  logic [RA_W-1:0]    i_id_rd,
  input  logic [RA_W-1:0]    i_ex_rd,
  input  logic [RA_W-1:0]    i_mem_rd,
  input  logic [RA_W-1:0]    i_wb_rd,
  input  logic               i_ex_wr,
  input  logic               i_mem_wr,
  input  logic               i_wb_wr,
  input  logic               i_mem_take,
  input  logic               i_halt_req,
  input  logic               i_step,
  output logic               o_pc_en,
  output logic               o_ifid_en,
  output logic               o_ifid_flush,
  output logic               o_idex_flush,
  output logic               o_exmem_flush,
  output logic               o_halted,
  output logic [STALL_W-1:0] o_stall_cnt
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]   o_perf_stall,
  output logic [CNT_W-1:0]   o_perf_flush,
  output logic [CNT_W-1:0]   o_perf_halt
`endif
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_STEP  = 2'd3;

  logic [1:0]         r_state;
  logic [STALL_W-1:0] r_cnt;

  logic               w_ex_hit;
  logic               w_mem_hit;
  logic               w_wb_hit;
  logic               w_hazard;
  logic [STALL_W-1:0] w_len;
  logic [1:0]         w_after;

  logic [1:0]         w_nxt_state;
  logic [STALL_W-1:0] w_nxt_cnt;
  logic               w_hz_bubble;

  assign w_ex_hit  = i_ex_wr  & ((i_id_rs_used & (i_ex_rd  == i_id_rs)) |
                                 (i_id_rd_used & (i_ex_rd  == i_id_rd)));
  assign w_mem_hit = i_mem_wr & ((i_id_rs_used & (i_mem_rd == i_id_rs)) |
                                 (i_id_rd_used & (i_mem_rd == i_id_rd)));
  assign w_wb_hit  = i_wb_wr  & ((i_id_rs_used & (i_wb_rd  == i_id_rs)) |
                                 (i_id_rd_used & (i_wb_rd  == i_id_rd)));
  assign w_hazard  = w_ex_hit | w_mem_hit | w_wb_hit;

  // Youngest writer dominates: it is the one furthest from reaching the regfile.
  assign w_len = w_ex_hit  ? STALL_W'(3) :
                 w_mem_hit ? STALL_W'(2) :
                 w_wb_hit  ? STALL_W'(1) : STALL_W'(0);

  assign w_after = i_halt_req ? S_HALT : S_RUN;

  always_comb begin
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_hz_bubble   = 1'b0;

    if (i_mem_take) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end

    case (r_state)
      S_RUN, S_STEP: begin
        if (i_mem_take) begin
          w_nxt_state = S_RUN;
          w_nxt_cnt   = '0;
        end else if (w_hazard) begin
          o_pc_en      = 1'b0;
          o_ifid_en    = 1'b0;
          o_idex_flush = 1'b1;
          w_hz_bubble  = 1'b1;
          // This cycle is the first bubble; a 1-cycle stall needs no STALL visit.
          if (w_len > STALL_W'(1)) begin
            w_nxt_state = S_STALL;
            w_nxt_cnt   = w_len - STALL_W'(1);
          end else begin
            w_nxt_state = w_after;
            w_nxt_cnt   = '0;
          end
        end else begin
          w_nxt_state = w_after;
          w_nxt_cnt   = '0;
        end
      end
      S_STALL: begin
        if (i_mem_take) begin
          w_nxt_state = S_RUN;
          w_nxt_cnt   = '0;
        end else begin
          o_pc_en      = 1'b0;
          o_ifid_en    = 1'b0;
          o_idex_flush = 1'b1;
          w_hz_bubble  = 1'b1;
          if (r_cnt <= STALL_W'(1)) begin
            w_nxt_state = w_after;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt - STALL_W'(1);
          end
        end
      end
      default: begin
        // HALT: a resolved branch still redirects the PC, but the state holds.
        if (!i_mem_take) begin
          o_pc_en      = 1'b0;
          o_ifid_en    = 1'b0;
          o_idex_flush = 1'b1;
        end
        w_nxt_cnt = '0;
        if (!i_halt_req) begin
          w_nxt_state = S_RUN;
        end else if (i_step) begin
          w_nxt_state = S_STEP;
        end else begin
          w_nxt_state = S_HALT;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign o_halted    = (r_state == S_HALT);
  assign o_stall_cnt = r_cnt;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;
  logic [CNT_W-1:0] r_perf_halt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_halt  <= '0;
    end else begin
      if (w_hz_bubble && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + CNT_W'(1);
      if (i_mem_take && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + CNT_W'(1);
      if ((r_state == S_HALT) && (r_perf_halt != '1))
        r_perf_halt <= r_perf_halt + CNT_W'(1);
    end
  end

  assign o_perf_stall = r_perf_stall;
  assign o_perf_flush = r_perf_flush;
  assign o_perf_halt  = r_perf_halt;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 8-bit 5-stage pipeline (IF/ID/EX/MEM/WB). It has no forwarding. It detects RAW hazards between the instruction in ID and older writers in EX/MEM/WB, then stalls PC and IF/ID while injecting ID/EX bubbles. On a taken jump/branch resolved in MEM it flushes the younger stages. It also provides an external halt/single-step hook for debug.

Parameters:
RA_W, 2, register-address width (4 architectural registers)
STALL_W, 2, stall-counter width; max stall 3 cycles
CNT_W, 16, performance-counter width (used only with HAZARD_PERF_EN)

Ports:
clock  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous, active-low reset
id_rs  in  RA_W  source register read by ID instruction
id_rs_used  in  1  ID instruction reads id_rs
id_rd_used  in  1  ID instruction also reads its rd field (accumulator-style ops)
id_rd  in  RA_W  rd field of ID instruction
ex_rd, mem_rd, wb_rd  in  RA_W  destination register in EX, MEM, WB
ex_wr, mem_wr, wb_wr  in  1  register-write enable of EX, MEM, WB instruction
mem_take  in  1  jump/branch taken, resolved in MEM (mux select into IF)
halt_req  in  1  level: debug halt request
step  in  1  pulse: advance exactly one instruction while halted
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID to NOP
idex_flush  out  1  clear ID/EX to NOP (control bits zero)
exmem_flush  out  1  clear EX/MEM control bits
halted  out  1  controller in HALT state
stall_cnt  out  STALL_W  remaining stall cycles (debug visibility)

Behaviour:
- States: RUN, STALL, HALT, STEP. Reset value: RUN, stall_cnt=0, halted=0. Outputs are combinational from state/inputs, so right after reset pc_en=1, ifid_en=1 and all flushes=0 (absent mem_take).
- Hazard match: (id_rs_used & src==id_rs) | (id_rd_used & src==id_rd), tested per stage with its wr bit. Required stall length: EX match -> 3, else MEM match -> 2, else WB match -> 1. The register file writes on the clock edge and is not bypassed, so a WB match still requires a stall.
- RUN: on hazard, go to STALL and load stall_cnt=len-1. In the same cycle drive pc_en=0, ifid_en=0, idex_flush=1. With no hazard, pc_en=ifid_en=1.
- STALL: pc_en=0, ifid_en=0, idex_flush=1 each cycle. stall_cnt decrements. Return to RUN when stall_cnt==0, with hazard re-evaluated in RUN that cycle. Total bubbles equal len.
- mem_take has highest priority in every state except HALT-with-no-step. In its cycle: ifid_flush=idex_flush=exmem_flush=1, pc_en=1 (PC loads target), ifid_en=1. Any pending stall is cancelled (stall_cnt=0, go to RUN). Penalty is 3 bubbles.
- mem_take and hazard in the same cycle: flush wins and no stall is started.
- HALT is entered from RUN or STALL when halt_req=1. In STALL the pending stall completes first, then HALT is entered. In HALT: pc_en=0, ifid_en=0, idex_flush=1, halted=1. Older instructions drain normally.
- In HALT, a step pulse moves to STEP for exactly one cycle. STEP behaves like one RUN cycle: if a hazard is found it goes to STALL then returns to HALT. After STEP or its stall, return to HALT if halt_req=1, else RUN.
- HALT -> RUN when halt_req deasserts.
- A mem_take arriving while in HALT is honoured (flushes fire, PC loads), and the state remains HALT.
- reset_n low at any time forces RUN and stall_cnt=0 immediately (asynchronous). Flushes are then inactive except for mem_take.
- Writes to register 0 are treated as ordinary registers (no hard-wired zero).

Optional Feature:
HAZARD_PERF_EN — when defined, adds three outputs, each CNT_W wide, saturating at all-ones and cleared by reset_n:
- perf_stall: counts cycles with idex_flush due to hazard
- perf_flush: counts mem_take events
- perf_halt: counts HALT cycles
When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ID reads r1 with EX writing r1 (ex_wr=1) -> pc_en=0 for 3 cycles, idex_flush=1 for 3 cycles, stall_cnt sequence 2,1,0, then pc_en=1.
- ID reads r2; MEM writes r2 and WB writes r3 -> 2-cycle stall. Same case with only WB writing r2 -> 1-cycle stall. Same case with ex_wr=0 and ex_rd=r2 -> no stall.
- Hazard active; mem_take=1 on the second stall cycle -> all three flushes=1 and pc_en=1 that cycle, stall_cnt=0, next cycle RUN with no residual bubble.
- mem_take and EX hazard in the same cycle -> flushes only, no STALL entry.
- halt_req=1 in RUN -> halted=1 next cycle with pc_en=0. Then step pulse -> exactly one cycle with pc_en=1, then halted=1 again. Deassert halt_req -> RUN.
- reset_n pulled low mid-STALL (stall_cnt=1) -> state RUN and stall_cnt=0 without waiting for a clock edge. With HAZARD_PERF_EN, the perf counters also read 0.
